// File: rtl/prio_scan_pkg.sv
// prio_scan_pkg: shared types and constants for the priority scan encoder
package prio_scan_pkg;
   typedef enum logic {MODE_SINGLE, MODE_SCAN} mode_e;
   typedef enum logic {ST_IDLE, ST_EMIT} state_e;
   localparam logic [7:0] NONE_CODE_DEF = 8'hF0;
endpackage

// File: rtl/prio_find.sv
// prio_find: combinational highest-set-bit finder with remainder mask and single-bit flag
module prio_find #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]         vec,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     any,
   output logic [WIDTH-1:0]         onehot_mask,
   output logic                     single
);
   localparam int IW = $clog2(WIDTH);
   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (vec[i]) idx = i[IW-1:0];
   end
   assign any         = |vec;
   assign onehot_mask = vec & ~(WIDTH'(1) << idx);
   // exactly one bit set iff something is set and nothing remains once it is cleared
   assign single      = any && (onehot_mask == '0);
endmodule

// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder: registered priority encoder emitting the highest set bit (SINGLE)
// or every set bit highest-first (SCAN) over valid/ready handshakes
module prio_scan_encoder
   import prio_scan_pkg::*;
#(
   parameter int         WIDTH     = 16,
   parameter int         OUTW      = 8,
   parameter logic [7:0] NONE_CODE = NONE_CODE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUTW-1:0]  out_code,
   output logic             out_last
);
   localparam int IW = $clog2(WIDTH);
   state_e           state;
   mode_e            mode_q;
   logic [WIDTH-1:0] vec_q, rest;
   logic [IW-1:0]    idx;
   logic             any, single;
   prio_find #(.WIDTH(WIDTH)) u_find (
      .vec         (vec_q),
      .idx         (idx),
      .any         (any),
      .onehot_mask (rest),
      .single      (single)
   );
   assign out_valid = state == ST_EMIT;
   assign out_last  = out_valid && (mode_q == MODE_SINGLE || single || !any);
   assign out_code  = !out_valid ? '0 : any ? OUTW'(idx) : OUTW'(NONE_CODE);
   // a final-beat handshake frees the slot in the same cycle, giving bubble-free job streams
   assign in_ready  = !rst && (state == ST_IDLE || (out_ready && out_last));
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         vec_q  <= '0;
         mode_q <= MODE_SINGLE;
      end else if (flush) begin
         state <= ST_IDLE;
      end else if (in_valid && in_ready) begin
         state  <= ST_EMIT;
         vec_q  <= in_vec;
         mode_q <= mode_e'(in_mode);
      end else if (out_valid && out_ready) begin
         vec_q <= rest;
         if (out_last) state <= ST_IDLE;
      end
   end
endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb_prio_scan_encoder: directed and randomized checks against a bit-list reference model
module tb_prio_scan_encoder;
   localparam int W  = 16;
   localparam int OW = 8;
   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, in_mode, out_valid, out_ready, out_last;
   logic [W-1:0]  in_vec;
   logic [OW-1:0] out_code;
   int            vectors = 0;
   int            errs = 0;
   int            exp_q[$];

   always #5 clk = ~clk;

   prio_scan_encoder #(.WIDTH(W), .OUTW(OW), .NONE_CODE(8'hF0)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // expected beat list: set-bit indices high to low, NONE for zero, only the first in SINGLE
   function automatic void build(input logic [W-1:0] v, input bit scan);
      int first;
      exp_q.delete();
      for (int i = W - 1; i >= 0; i--)
         if (v[i]) exp_q.push_back(i);
      if (exp_q.size() == 0) exp_q.push_back(32'hF0);
      if (!scan) begin
         first = exp_q[0];
         exp_q.delete();
         exp_q.push_back(first);
      end
   endfunction

   task automatic run_job(input logic [W-1:0] v, input bit scan, input int stall_first, input bit rnd);
      int stall;
      bit last;
      stall = stall_first;
      build(v, scan);
      in_vec   = v;
      in_mode  = scan;
      in_valid = 1'b1;
      #1;
      chk("idle_in_ready", in_ready, 1);
      tick;
      in_valid = 1'b0;
      in_vec   = W'($urandom);
      in_mode  = 1'($urandom);
      while (exp_q.size() > 0) begin
         last      = exp_q.size() == 1;
         out_ready = stall > 0 ? 1'b0 : rnd ? ($urandom_range(3) != 0) : 1'b1;
         #1;
         chk("beat_valid", out_valid, 1);
         chk("beat_code", out_code, exp_q[0]);
         chk("beat_last", out_last, last);
         chk("beat_in_ready", in_ready, out_ready && last);
         tick;
         if (out_ready) void'(exp_q.pop_front());
         if (stall > 0) stall--;
      end
      out_ready = 1'b0;
      chk("done_valid", out_valid, 0);
      chk("done_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [W-1:0] stream [4];
      logic [W-1:0] rv;
      stream = '{16'h0001, 16'h0002, 16'h0004, 16'h8000};
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0; in_mode = 1'b0;
      tick;
      tick;
      chk("rst_valid", out_valid, 0);
      chk("rst_code", out_code, 0);
      chk("rst_last", out_last, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      tick;
      run_job(16'h2AF1, 1'b0, 0, 1'b0);
      run_job(16'h2AF1, 1'b1, 0, 1'b0);
      run_job(16'h0000, 1'b0, 0, 1'b0);
      run_job(16'h0000, 1'b1, 0, 1'b0);
      run_job(16'h0001, 1'b0, 0, 1'b0);
      run_job(16'hC000, 1'b0, 0, 1'b0);
      run_job(16'h8001, 1'b1, 3, 1'b0);
      // single-mode stream with no bubbles
      out_ready = 1'b1;
      in_mode   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_vec   = stream[k];
         in_valid = 1'b1;
         #1;
         chk("stream_in_ready", in_ready, 1);
         tick;
         chk("stream_valid", out_valid, 1);
         chk("stream_code", out_code, k == 3 ? 15 : k);
      end
      in_valid = 1'b0;
      tick;
      chk("stream_end_valid", out_valid, 0);
      // flush beats a simultaneous accept
      in_valid = 1'b1; in_vec = 16'h0010; flush = 1'b1;
      tick;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_prio_valid", out_valid, 0);
      // flush and reset mid scan
      for (int r = 0; r < 2; r++) begin
         in_valid = 1'b1; in_vec = 16'hFFFF; in_mode = 1'b1; out_ready = 1'b1;
         tick;
         in_valid = 1'b0;
         chk("abort_b0", out_code, 15);
         tick;
         chk("abort_b1", out_code, 14);
         tick;
         chk("abort_b2", out_code, 13);
         if (r == 0) flush = 1'b1; else rst = 1'b1;
         tick;
         chk("abort_valid", out_valid, 0);
         chk("abort_code", out_code, 0);
         chk("abort_last", out_last, 0);
         chk("abort_in_ready", in_ready, r == 0 ? 1 : 0);
         flush = 1'b0; rst = 1'b0;
         tick;
         chk("abort_idle_valid", out_valid, 0);
         chk("abort_idle_in_ready", in_ready, 1);
      end
      out_ready = 1'b0;
      for (int n = 0; n < 40; n++) begin
         rv = W'($urandom);
         case ($urandom_range(3))
            0: rv = '0;
            1: rv = rv & W'($urandom) & W'($urandom);
            default: ;
         endcase
         run_job(rv, 1'($urandom), $urandom_range(2), 1'b1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
